// File: rtl/light_instr_parser.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | light_instr_parser: ASCII light-puzzle lines -> packed command words.    |
// | Optional: PARSER_ERR_COUNT_EN enables the malformed-line counter.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module light_instr_parser #(
    parameter int POSITION_BITS     = 12,
    parameter int INSTRUCTION_WIDTH = 50,
    parameter int ERR_CNT_WIDTH     = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [7:0]                   in_data,
    input  logic                         in_last,
    output logic                         instr_valid,
    input  logic                         instr_ready,
    output logic [INSTRUCTION_WIDTH-1:0] instr_data,
    output logic                         instr_last,
    output logic                         parse_done,
    output logic [ERR_CNT_WIDTH-1:0]     err_count
);

    typedef enum logic [2:0] {
        S_OP    = 3'd0,
        S_NUM   = 3'd1,
        S_SEP   = 3'd2,
        S_FLUSH = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                         state_q, state_d;
    logic                           ready_en_q;
    logic                           saw_g_q, saw_g_d, saw_f_q, saw_f_d;
    logic                           has_letter_q, has_letter_d;
    logic [2:0]                     cnt_q, cnt_d;
    logic [POSITION_BITS-1:0]       cur_q, cur_d;
    logic [POSITION_BITS-1:0]       fld_q [4];
    logic [POSITION_BITS-1:0]       fld_d [4];
    logic                           pend_valid_q, pend_valid_d;
    logic [INSTRUCTION_WIDTH-1:0]   pend_data_q, pend_data_d;
    logic                           out_valid_q, out_valid_d;
    logic [INSTRUCTION_WIDTH-1:0]   out_data_q, out_data_d;
    logic                           out_last_q, out_last_d;
    logic                           done_q, done_d;

    logic                           w_accept, w_digit, w_alpha, w_cr, w_nl;
    logic                           w_in_num, w_cont, w_line_end, w_fin;
    logic                           w_has_letter, w_g, w_f, w_line_valid;
    logic [1:0]                     w_op;
    logic [2:0]                     w_cnt_fin;
    logic [POSITION_BITS-1:0]       w_new_cur;
    logic [INSTRUCTION_WIDTH-1:0]   w_word;

    assign in_ready = ready_en_q && (state_q != S_FLUSH) && (state_q != S_DONE)
                      && !(pend_valid_q && out_valid_q);

    assign w_accept   = in_valid && in_ready;
    assign w_digit    = (in_data >= 8'h30) && (in_data <= 8'h39);
    assign w_alpha    = ((in_data >= 8'h61) && (in_data <= 8'h7a)) ||
                        ((in_data >= 8'h41) && (in_data <= 8'h5a));
    assign w_cr       = (in_data == 8'h0d);
    assign w_nl       = (in_data == 8'h0a);
    assign w_in_num   = (state_q == S_NUM);
    // '\r' is transparent: it neither extends nor ends a digit run.
    assign w_cont     = w_digit || (w_cr && w_in_num);
    assign w_line_end = w_nl || in_last;
    assign w_fin      = (w_in_num && !w_cont) || (w_cont && w_line_end);
    assign w_new_cur  = !w_digit ? cur_q :
                        w_in_num ? ((cur_q << 3) + (cur_q << 1) +
                                    {{(POSITION_BITS-4){1'b0}}, in_data[3:0]})
                                 : {{(POSITION_BITS-4){1'b0}}, in_data[3:0]};
    assign w_cnt_fin  = !w_fin ? cnt_q : (cnt_q == 3'd5) ? 3'd5 : cnt_q + 3'd1;
    assign w_has_letter = has_letter_q || w_alpha;
    assign w_g        = saw_g_q || ((state_q == S_OP) && (in_data == 8'h67));
    assign w_f        = saw_f_q || ((state_q == S_OP) && (in_data == 8'h66));
    assign w_op       = w_g ? 2'b01 : w_f ? 2'b00 : 2'b11;
    assign w_line_valid = w_line_end && (w_cnt_fin == 3'd4);

    always_comb begin
        state_d      = state_q;
        saw_g_d      = saw_g_q;
        saw_f_d      = saw_f_q;
        has_letter_d = has_letter_q;
        cnt_d        = cnt_q;
        cur_d        = cur_q;
        fld_d        = fld_q;
        pend_valid_d = pend_valid_q;
        pend_data_d  = pend_data_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_last_d   = out_last_q;
        done_d       = done_q;

        if (out_valid_q && instr_ready) begin
            out_valid_d = 1'b0;
            if (out_last_q)
                done_d = 1'b1;
        end

        if (w_fin && (cnt_q < 3'd4))
            fld_d[cnt_q[1:0]] = w_new_cur;
        w_word = {w_op, fld_d[0], fld_d[1], fld_d[2], fld_d[3]};

        if (w_accept) begin
            if (w_line_end) begin
                cnt_d        = 3'd0;
                cur_d        = '0;
                saw_g_d      = 1'b0;
                saw_f_d      = 1'b0;
                has_letter_d = 1'b0;
                state_d      = in_last ? S_FLUSH : S_OP;
                if (w_line_valid) begin
                    // Lookahead: an older pending command can now go out, never last.
                    if (pend_valid_q) begin
                        out_valid_d = 1'b1;
                        out_data_d  = pend_data_q;
                        out_last_d  = 1'b0;
                    end
                    pend_valid_d = 1'b1;
                    pend_data_d  = w_word;
                end
            end else begin
                cnt_d        = w_cnt_fin;
                cur_d        = w_new_cur;
                saw_g_d      = w_g;
                saw_f_d      = w_f;
                has_letter_d = w_has_letter;
                state_d      = w_cont ? S_NUM : (state_q == S_OP) ? S_OP : S_SEP;
            end
        end else if (state_q == S_FLUSH) begin
            if (!pend_valid_q) begin
                state_d = S_DONE;
                done_d  = 1'b1;
            end else if (!out_valid_q || instr_ready) begin
                out_valid_d  = 1'b1;
                out_data_d   = pend_data_q;
                out_last_d   = 1'b1;
                pend_valid_d = 1'b0;
                state_d      = S_DONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_OP;
            ready_en_q   <= 1'b0;
            saw_g_q      <= 1'b0;
            saw_f_q      <= 1'b0;
            has_letter_q <= 1'b0;
            cnt_q        <= 3'd0;
            cur_q        <= '0;
            fld_q        <= '{default: '0};
            pend_valid_q <= 1'b0;
            pend_data_q  <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_last_q   <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ready_en_q   <= 1'b1;
            saw_g_q      <= saw_g_d;
            saw_f_q      <= saw_f_d;
            has_letter_q <= has_letter_d;
            cnt_q        <= cnt_d;
            cur_q        <= cur_d;
            fld_q        <= fld_d;
            pend_valid_q <= pend_valid_d;
            pend_data_q  <= pend_data_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_last_q   <= out_last_d;
            done_q       <= done_d;
        end
    end

    assign instr_valid = out_valid_q;
    assign instr_data  = out_data_q;
    assign instr_last  = out_last_q;
    assign parse_done  = done_q;

`ifdef PARSER_ERR_COUNT_EN
    logic                     w_line_bad;
    logic [ERR_CNT_WIDTH-1:0] err_q, err_d;

    // Empty lines (no numbers, no letters) are not errors.
    assign w_line_bad = w_line_end && (w_cnt_fin != 3'd4) &&
                        !((w_cnt_fin == 3'd0) && !w_has_letter);

    always_comb begin
        err_d = err_q;
        if (w_accept && w_line_bad && (err_q != {ERR_CNT_WIDTH{1'b1}}))
            err_d = err_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset)
            err_q <= '0;
        else
            err_q <= err_d;
    end

    assign err_count = err_q;
`else
    assign err_count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_light_instr_parser.sv
`default_nettype none
// Directed bench for light_instr_parser: hand-computed command words and status.
module tb_light_instr_parser;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = 8'h00;
    logic        in_last = 1'b0;
    logic        instr_valid;
    logic        instr_ready = 1'b1;
    logic [49:0] instr_data;
    logic        instr_last;
    logic        parse_done;
    logic [15:0] err_count;

    int compared = 0;
    int mismatched = 0;
    logic [50:0] q[$];
    logic [49:0] held;
    logic        stable;
    logic        rdy_low;
    int          exp_err_c;

    always #5 clk = ~clk;

    light_instr_parser dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last     (in_last),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_data  (instr_data),
        .instr_last  (instr_last),
        .parse_done  (parse_done),
        .err_count   (err_count)
    );

    // Handshake observed mid-cycle; it completes at the following rising edge.
    always @(negedge clk)
        if (!reset && instr_valid && instr_ready)
            q.push_back({instr_last, instr_data});

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [49:0] mk(input logic [1:0] op, input int a, input int b,
                                       input int c, input int d);
        return {op, a[11:0], b[11:0], c[11:0], d[11:0]};
    endfunction

    task automatic send_byte(input logic [7:0] b, input logic l);
        int n = 0;
        in_valid = 1'b1;
        in_data  = b;
        in_last  = l;
        while (!in_ready && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) check("in_ready_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_str(input string s, input logic last_at_end);
        for (int i = 0; i < s.len(); i++)
            send_byte(s[i], last_at_end && (i == s.len() - 1));
    endtask

    task automatic wait_words(input int n, input string tag);
        int c = 0;
        while (q.size() < n && c < 2000) begin
            @(posedge clk); #1;
            c++;
        end
        check(tag, q.size(), n);
    endtask

    task automatic wait_done(input string tag);
        int c = 0;
        while (!parse_done && c < 200) begin
            @(posedge clk); #1;
            c++;
        end
        check(tag, parse_done, 1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        q.delete();
    endtask

    initial begin
`ifdef PARSER_ERR_COUNT_EN
        exp_err_c = 1;
`else
        exp_err_c = 0;
`endif
        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_instr_valid", instr_valid, 0);
        check("rst_instr_last", instr_last, 0);
        check("rst_instr_data", instr_data, 0);
        check("rst_parse_done", parse_done, 0);
        check("rst_err_count", err_count, 0);
        reset = 1'b0;
        check("in_ready_low_at_release", in_ready, 0);
        @(posedge clk); #1;
        check("in_ready_rises", in_ready, 1);

        // Single full-range command with trailing newline
        send_str("turn on 0,0 through 999,999\n", 1'b1);
        wait_words(1, "a_count");
        check("a_data", q[0][49:0], mk(2'b11, 0, 0, 999, 999));
        check("a_last", q[0][50], 1);
        wait_done("a_done");
        check("a_err", err_count, 0);

        // CRLF line followed by a line with no newline
        do_reset();
        send_str("toggle 1,2 through 3,4\r\nturn off 5,6 through 7,8", 1'b1);
        wait_words(2, "b_count");
        check("b_w0_data", q[0][49:0], mk(2'b01, 1, 2, 3, 4));
        check("b_w0_last", q[0][50], 0);
        check("b_w1_data", q[1][49:0], mk(2'b00, 5, 6, 7, 8));
        check("b_w1_last", q[1][50], 1);
        wait_done("b_done");

        // Malformed line and trailing empty line
        do_reset();
        send_str("turn on 1,1 through 2,2\nturn on 5,5\n\n", 1'b1);
        wait_done("c_done");
        check("c_count", q.size(), 1);
        check("c_data", q[0][49:0], mk(2'b11, 1, 1, 2, 2));
        check("c_last", q[0][50], 1);
        check("c_err", err_count, exp_err_c);

        // Backpressure: downstream stalled after the first word
        do_reset();
        instr_ready = 1'b0;
        send_str("turn on 1,2 through 3,4\n", 1'b0);
        send_str("toggle 10,20 through 30,40\n", 1'b0);
        check("d_valid", instr_valid, 1);
        check("d_held_data", instr_data, mk(2'b11, 1, 2, 3, 4));
        check("d_in_ready_low", in_ready, 0);
        held = instr_data;
        stable = 1'b1;
        rdy_low = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (instr_data !== held || instr_valid !== 1'b1) stable = 1'b0;
            if (in_ready !== 1'b0) rdy_low = 1'b0;
        end
        check("d_stable", stable, 1);
        check("d_in_ready_held_low", rdy_low, 1);
        instr_ready = 1'b1;
        send_str("turn off 100,4097 through 300,4095\n", 1'b1);
        wait_words(3, "d_count");
        check("d_w0", q[0], {1'b0, mk(2'b11, 1, 2, 3, 4)});
        check("d_w1", q[1], {1'b0, mk(2'b01, 10, 20, 30, 40)});
        check("d_w2", q[2], {1'b1, mk(2'b00, 100, 1, 300, 4095)});
        wait_done("d_done");

        // Only empty lines: no command at all
        do_reset();
        send_str("\n\n", 1'b1);
        wait_done("e_done");
        check("e_count", q.size(), 0);
        check("e_valid", instr_valid, 0);
        check("e_err", err_count, 0);

        // Reset while a word waits at the output
        do_reset();
        instr_ready = 1'b0;
        send_str("toggle 9,9 through 9,9\n", 1'b1);
        for (int i = 0; i < 20 && !instr_valid; i++) begin
            @(posedge clk); #1;
        end
        check("f_valid_before", instr_valid, 1);
        check("f_data_before", instr_data, mk(2'b01, 9, 9, 9, 9));
        reset = 1'b1;
        @(posedge clk); #1;
        check("f_valid_after_rst", instr_valid, 0);
        check("f_done_after_rst", parse_done, 0);
        reset = 1'b0;
        instr_ready = 1'b1;
        @(posedge clk); #1;
        q.delete();
        send_str("turn on 7,8 through 9,10\n", 1'b1);
        wait_words(1, "f_count");
        check("f_word", q[0], {1'b1, mk(2'b11, 7, 8, 9, 10)});
        wait_done("f_done");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/light_instr_parser.md
Name: light_instr_parser

Overview:
- Upstream stage of the light display engine: converts the ASCII puzzle input ("turn on 0,0 through 999,999", "toggle ...", "turn off ...") into packed command words.
- Byte stream in with valid/ready/last; one command word out per well-formed line via valid/ready/last.
- Holds one completed command in a lookahead register so the final command carries instr_last even when trailing lines are empty or malformed.

Parameters:
POSITION_BITS, 12, width of each coordinate field
INSTRUCTION_WIDTH, 50, output word width (2 + 4*POSITION_BITS)
ERR_CNT_WIDTH, 16, width of the malformed-line counter

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
in_valid  in  1  input byte valid
in_ready  out  1  input byte accepted when in_valid && in_ready
in_data  in  8  ASCII byte
in_last  in  1  marks the final byte of the input
instr_valid  out  1  command word valid
instr_ready  in  1  downstream accept
instr_data  out  INSTRUCTION_WIDTH  {op[1:0], start_row, start_col, end_row, end_col}
instr_last  out  1  final command of the stream
parse_done  out  1  sticky; all input consumed and last command handed off (or none existed)
err_count  out  ERR_CNT_WIDTH  malformed lines dropped (see Optional Feature)

Behaviour:
- Reset values: in_ready=0, instr_valid=0, instr_last=0, instr_data=0, parse_done=0, err_count=0. in_ready rises the cycle after reset deasserts.
- Op decode, from letters seen before the first digit of a line: 'g' -> TOGGLE 2'b01; 'f' -> TURN_OFF 2'b00; neither -> TURN_ON 2'b11.
- Field mapping: numbers in order map to start_row, start_col, end_row, end_col. The first number of each "x,y" pair is the row.
- Number accumulation: value = value*10 + digit, truncated to POSITION_BITS (modulo 2^12). Any non-digit ends a number run; ',' and the text " through " are ordinary separators.
- Line terminators: '\n' ends a line; '\r' is ignored. A byte with in_last also ends the line after that byte is processed.
- Line classification:
  - Exactly 4 numbers: valid command.
  - 0 numbers and no letters: empty line, silently ignored.
  - Anything else: malformed; dropped and err_count incremented.
- FSM states:
  - S_OP: letters before the first digit.
  - S_NUM: inside a digit run.
  - S_SEP: between number runs.
  - S_FLUSH: end of input seen, pending command not yet moved to output.
  - S_DONE: terminal.
- Transitions: S_OP/S_SEP -> S_NUM on a digit; S_NUM -> S_SEP on a non-digit; line end -> S_OP; in_last -> S_FLUSH; S_FLUSH -> S_DONE once the pending command is loaded to output (or immediately if nothing is pending).
- Lookahead:
  - A valid line completes into the pending register.
  - If pending is already occupied, the old pending moves to the output stage with instr_last=0 in the same cycle.
  - in_ready = 0 when pending is occupied and instr_valid=1 (no room), and in S_FLUSH/S_DONE.
- Output stage: instr_valid rises the cycle after the terminating byte is accepted, or after output room frees. instr_data/instr_last are held stable until instr_valid && instr_ready, then instr_valid drops in the next cycle unless a new word is loaded.
- S_FLUSH: waits for the output stage to be empty, loads pending with instr_last=1, then enters S_DONE. parse_done sets when that word's handshake completes. If no valid command ever existed, parse_done sets on entry to S_DONE with no emission.
- err_count saturates at its maximum value.
- Reset mid-line or mid-handshake discards all partial state; instr_valid drops in the following cycle.

Optional Feature:
- Macro: PARSER_ERR_COUNT_EN.
- Defined: err_count counts malformed lines as described above.
- Undefined: counter logic is omitted, err_count is tied to 0, and malformed lines are still dropped.

Test Plan:
- "turn on 0,0 through 999,999\n" with in_last on '\n' -> one word {2'b11,12'd0,12'd0,12'd999,12'd999}, instr_last=1, then parse_done=1.
- "toggle 1,2 through 3,4\r\nturn off 5,6 through 7,8" with in_last on '8' and no newline -> word 1 op=01 (1,2,3,4) last=0; word 2 op=00 (5,6,7,8) last=1.
- "turn on 1,1 through 2,2\nturn on 5,5\n\n" with in_last on the final '\n' -> one word (1,1,2,2) with last=1; err_count=1 (0 with macro undefined).
- Three valid lines, instr_ready held low 200 cycles after the first word -> instr_data stable throughout, in_ready drops once pending fills, no words lost, last=1 only on the third word.
- Input "\n\n" with in_last -> no word emitted, parse_done=1, err_count=0.
- reset pulsed while the word from "toggle 9,9 through 9,9\n" is waiting -> instr_valid=0 the next cycle; a subsequent clean stream parses correctly.
